// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, the NOP word and the fetch FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select for the fetch stage: jump beats taken-beq, otherwise sequential.
module ifu_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] offset_bytes;

  // Word offset to byte offset; the top two offset bits fall off, 32-bit wrap.
  assign offset_bytes = branch_offset << 2;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + offset_bytes;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// holds the returned word in the instruction register until it is consumed.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_req stays high with imem_addr stable until the cycle
  // imem_ack is sampled high (or the request times out). Downstream takes the
  // instruction on any edge where instr_valid=1 and stall=0.

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0] pc, pc_nxt, instr_nxt, next_pc;
  logic valid_nxt, err_nxt, req_nxt;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = get_opcode(instr);
  assign dbg_state = state;

  ifu_next_pc u_next_pc (
    .pc_plus4      (pc_plus4),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        cnt_nxt   = '0;
      end
      FETCH: begin
        cnt_nxt = '0;
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = VALID;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A late ack still wins over a timeout landing in the same cycle.
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = VALID;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      VALID: begin
        if (!stall) begin
          valid_nxt = 1'b0;
          pc_nxt    = next_pc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_nxt = (state_nxt == FETCH) || (state_nxt == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pc          <= RESET_PC;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      imem_req    <= req_nxt;
      fetch_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, ack latency, stall hold, beq/j redirect,
// PC wrap, request timeout and reset during an outstanding request.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .fetch_err     (fetch_err),
    .dbg_state     (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic wait_req(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic serve(input int lat, input logic [31:0] word, output logic stable);
    logic [31:0] a0;
    a0 = imem_addr;
    stable = 1'b1;
    repeat (lat) begin
      @(negedge clk);
      if (!imem_req || imem_addr !== a0) stable = 1'b0;
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic fetch_one(input int lat, input logic [31:0] word,
                           output logic seen, output logic [31:0] addr, output logic stable);
    wait_req(seen);
    addr = imem_addr;
    stable = 1'b0;
    if (seen) serve(lat, word, stable);
  endtask

  task automatic consume(input logic b, input logic z, input logic [31:0] off,
                         input logic j, input logic [25:0] tgt);
    stall         = 1'b0;
    branch        = b;
    zero          = z;
    branch_offset = off;
    jump          = j;
    jump_target   = tgt;
    @(negedge clk);
    stall         = 1'b1;
    branch        = 1'b0;
    zero          = 1'b0;
    branch_offset = 32'h0;
    jump          = 1'b0;
    jump_target   = 26'h0;
  endtask

  // Scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b1;
    branch = 1'b0; zero = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_target = 26'h0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", pc_out); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req_rise: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_first_fetch;
    logic st;
    serve(0, 32'h8C08_0004, st);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b want 1", instr_valid); end
    checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL ff_opcode: got %h want 23", opcode); end
    checks++; if (instr !== 32'h8C08_0004) begin errors++; $display("FAIL ff_instr: got %h want 8c080004", instr); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL ff_pc_plus4: got %h want 00000004", pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_req_low: got %b want 0", imem_req); end
    consume(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL ff_next_addr: got %h want 00000004", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_consumed: got %b want 0", instr_valid); end
  endtask

  task automatic test_ack_latency_stall;
    logic seen, st, hold_ok;
    logic [31:0] a;
    fetch_one(3, 32'h2008_0007, seen, a, st);
    checks++; if (!seen || a !== 32'h4) begin errors++; $display("FAIL lat_addr: got %h want 00000004", a); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL lat_req_stable: got %b want 1", st); end
    // Redirect inputs while stalled must be ignored.
    jump = 1'b1; jump_target = 26'h3FF_FFFF; branch = 1'b1; zero = 1'b1;
    hold_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (instr !== 32'h2008_0007 || pc_out !== 32'h4 || instr_valid !== 1'b1 || imem_req !== 1'b0)
        hold_ok = 1'b0;
    end
    jump = 1'b0; jump_target = 26'h0; branch = 1'b0; zero = 1'b0;
    checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b want 1", hold_ok); end
    consume(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next_addr: got %h want 00000008", imem_addr); end
  endtask

  task automatic test_beq;
    logic seen, st;
    logic [31:0] a;
    fetch_one(1, 32'h0800_0004, seen, a, st);
    consume(1'b0, 1'b0, 32'h0, 1'b1, 26'h4);
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL j_to_10: got %h want 00000010", imem_addr); end
    fetch_one(0, 32'h1109_FFFE, seen, a, st);
    consume(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h0C) begin errors++; $display("FAIL beq_taken: got %h want 0000000c", imem_addr); end
    fetch_one(0, 32'h0800_0004, seen, a, st);
    consume(1'b0, 1'b0, 32'h0, 1'b1, 26'h4);
    fetch_one(0, 32'h1109_FFFE, seen, a, st);
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL beq_refetch: got %h want 00000010", a); end
    consume(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL beq_not_taken: got %h want 00000014", imem_addr); end
  endtask

  task automatic test_jump_and_wrap;
    logic seen, st;
    logic [31:0] a;
    fetch_one(0, 32'h1109_0000, seen, a, st);
    consume(1'b1, 1'b1, 32'h0FFF_FFFA, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h4000_0000) begin errors++; $display("FAIL beq_far: got %h want 40000000", imem_addr); end
    fetch_one(0, 32'h0800_0100, seen, a, st);
    checks++; if (pc_plus4 !== 32'h4000_0004) begin errors++; $display("FAIL j_pc_plus4: got %h want 40000004", pc_plus4); end
    consume(1'b1, 1'b1, 32'h0000_0005, 1'b1, 26'h000_0100);
    checks++; if (imem_addr !== 32'h4000_0400) begin errors++; $display("FAIL j_priority: got %h want 40000400", imem_addr); end
    fetch_one(0, 32'h1109_0000, seen, a, st);
    consume(1'b1, 1'b1, 32'hEFFF_FEFE, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_wrap: got %h want fffffffc", imem_addr); end
    fetch_one(0, 32'h0000_0020, seen, a, st);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc_plus4_wrap: got %h want 00000000", pc_plus4); end
    consume(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_wrap: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_timeout;
    int hi;
    logic early_err, st;
    hi = 0;
    early_err = 1'b0;
    while (imem_req && hi < 40) begin
      hi++;
      if (fetch_err) early_err = 1'b1;
      if (imem_addr !== 32'h0) early_err = 1'b1;
      @(negedge clk);
    end
    checks++; if (hi !== 17) begin errors++; $display("FAIL to_req_cycles: got %0d want 17", hi); end
    checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL to_early_err: got %b want 0", early_err); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse: got %b want 1", fetch_err); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_err_single: got %b want 0", fetch_err); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL to_rerequest: req %b addr %h want 1 00000000", imem_req, imem_addr); end
    serve(2, 32'hAC08_0008, st);
    checks++; if (instr_valid !== 1'b1 || instr !== 32'hAC08_0008) begin errors++; $display("FAIL to_late_ack: valid %b instr %h want 1 ac080008", instr_valid, instr); end
  endtask

  task automatic test_reset_in_wait;
    logic st, seen;
    consume(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rw_addr: got %h want 00000004", imem_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rw_instr: got %h want 00000000", instr); end
    checks++; if (pc_out !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_pc_req: pc %h req %b want 00000000 0", pc_out, imem_req); end
    @(negedge clk);
    wait_req(seen);
    checks++; if (!seen || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_refetch: seen %b addr %h want 1 00000000", seen, imem_addr); end
    serve(0, 32'h0000_0020, st);
    checks++; if (instr_valid !== 1'b1 || opcode !== 6'h00) begin errors++; $display("FAIL rw_fetch_ok: valid %b opcode %h want 1 00", instr_valid, opcode); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_ack_latency_stall();
    test_beq();
    test_jump_and_wrap();
    test_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
